// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiters.
package fifo_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW:0] pos;

    // Scan from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(N - 1 - k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter granting bursts of up to BURST beats from NREQ requesters into one FIFO.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned BURST = DEF_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic                  busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          req_g;
    logic          accept;

    rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign req_g  = req[gidx_q];
    assign accept = (state_q == StGrant) && req_g && !fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d    = StGrant;
                    grant_d    = NREQ'(1) << pick_idx;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            StGrant: begin
                // Release on a dropped request or on the last beat of the burst.
                if (!req_g || (accept && beat_cnt_q == LAST_BEAT)) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    rr_ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant      = grant_q;
        busy       = (state_q == StGrant);
        fifo_wr_en = accept;
        ack        = accept ? grant_q : '0;
        fifo_wdata = '0;
        if (state_q == StGrant) begin
            fifo_wdata = wdata_in[gidx_q*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: NREQ=4/BURST=4 instance plus an NREQ=3/BURST=2 instance.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata_in;
    logic [3:0]  grant, ack;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic        busy;

    logic [2:0]  req3;
    logic [23:0] wdata3;
    logic [2:0]  grant3, ack3;
    logic        full3;
    logic        wr_en3;
    logic [7:0]  fifo_wdata3;
    logic        busy3;

    int errors = 0;
    int checks = 0;
    int writes = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .WIDTH (8),
        .NREQ  (4),
        .BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wdata_in   (wdata_in),
        .grant      (grant),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    fifo_rr_arbiter #(
        .WIDTH (8),
        .NREQ  (3),
        .BURST (2)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req        (req3),
        .wdata_in   (wdata3),
        .grant      (grant3),
        .ack        (ack3),
        .fifo_full  (full3),
        .fifo_wr_en (wr_en3),
        .fifo_wdata (fifo_wdata3),
        .busy       (busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit d3, input logic [3:0] r, input logic f);
        @(negedge clk);
        if (d3) req3 = r[2:0];
        else req = r;
        fifo_full = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        req3 = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One nibble per cycle, first cycle in the most significant nibble.
    task automatic seq(input string tag, input bit d3, input logic [3:0] r, input logic f,
                       input int n, input logic [127:0] av, input logic [127:0] gv);
        logic [3:0] ea, eg, oa, og;
        logic [7:0] ed;
        for (int k = 0; k < n; k++) begin
            tick(d3, r, f);
            ea = av[4*(n-1-k) +: 4];
            eg = gv[4*(n-1-k) +: 4];
            oa = d3 ? {1'b0, ack3} : ack;
            og = d3 ? {1'b0, grant3} : grant;
            chk($sformatf("%s_ack%0d", tag, k), 32'(oa), 32'(ea));
            chk($sformatf("%s_grant%0d", tag, k), 32'(og), 32'(eg));
            if (!d3 && ea != 4'd0) begin
                ed = 8'hA0;
                for (int i = 0; i < 4; i++) if (ea[i]) ed = 8'hA0 + 8'(i);
                chk($sformatf("%s_wdata%0d", tag, k), 32'(fifo_wdata), 32'(ed));
            end
            if (!d3 && fifo_wr_en) writes++;
            if (!d3 && f) chk($sformatf("%s_nowr_full%0d", tag, k), 32'(fifo_wr_en), 32'd0);
        end
    endtask

    initial begin
        wdata_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        wdata3    = {8'hB2, 8'hB1, 8'hB0};
        full3     = 1'b0;
        rst       = 1'b1;
        req       = 4'b1111;
        req3      = 3'b111;
        fifo_full = 1'b0;

        // Reset holds everything clear even with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant3", 32'(grant3), 32'd0);
        rst = 1'b0;
        req = '0;
        req3 = '0;

        // Two requesters alternate, one bubble between bursts.
        seq("alt", 1'b0, 4'b0101, 1'b0, 12, 48'h011110444401, 48'h011110444401);

        // Lone requester 3 drops after two beats; pointer wraps to 0.
        do_reset();
        writes = 0;
        seq("drop", 1'b0, 4'b1000, 1'b0, 3, 12'h088, 12'h088);
        tick(1'b0, 4'b0000, 1'b0);
        chk("drop_grant_held", 32'(grant), 32'h8);
        chk("drop_ack", 32'(ack), 32'd0);
        chk("drop_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("drop_busy", 32'(busy), 32'd1);
        tick(1'b0, 4'b1010, 1'b0);
        chk("drop_idle_grant", 32'(grant), 32'd0);
        chk("drop_idle_busy", 32'(busy), 32'd0);
        chk("drop_idle_wdata", 32'(fifo_wdata), 32'd0);
        tick(1'b0, 4'b1010, 1'b0);
        chk("drop_ptr0_pick1", 32'(grant), 32'h2);
        chk("drop_writes", 32'(writes), 32'd2);

        // FIFO full for three cycles mid-burst.
        do_reset();
        writes = 0;
        seq("full_a", 1'b0, 4'b0010, 1'b0, 2, 8'h02, 8'h02);
        seq("full_b", 1'b0, 4'b0010, 1'b1, 3, 12'h000, 12'h222);
        seq("full_c", 1'b0, 4'b0010, 1'b0, 4, 16'h2220, 16'h2220);
        chk("full_writes", 32'(writes), 32'd4);

        // All requesters: order 0,1,2,3,0 with four beats each.
        do_reset();
        seq("all", 1'b0, 4'b1111, 1'b0, 25, 100'h0111102222044440888801111,
            100'h0111102222044440888801111);

        // Asynchronous reset between edges during beat 2, then restart at index 0.
        do_reset();
        seq("arst", 1'b0, 4'b0100, 1'b0, 3, 12'h044, 12'h044);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wdata", 32'(fifo_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        #1;
        chk("arst_idle", 32'(grant), 32'd0);
        tick(1'b0, 4'b0010, 1'b0);
        chk("arst_regrant", 32'(grant), 32'h2);
        chk("arst_reack", 32'(ack), 32'h2);

        // Three requesters: pointer cycles 0,1,2,0.
        do_reset();
        seq("n3", 1'b1, 4'b0111, 1'b0, 12, 48'h011022044011, 48'h011022044011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
